// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one combinational ALU between two
// requesters, with valid/ready handshakes on both commands and responses.
//   clk, rst_n            clock (rising edge), async active-low reset
//   reqN_valid/ready      command handshake for requester N (N = 0, 1)
//   reqN_a/_b/_op         operands and op code of requester N
//   rspN_valid/ready      response handshake for requester N
//   rsp_result/_carry/_overflow/_zero/_err  captured response (shared)
//   alu_a/_b/_op          operands driven to the ALU (zero outside EXEC)
//   alu_result/_carry/_overflow/_zero       ALU outputs
// Optional feature: define ALU_DIV0_TRAP_EN to trap divide-by-zero (op 3, b == 0)
// without driving the ALU; otherwise rsp_err is tied to 0.
module alu_arbiter #(
  parameter int WIDTH = 8,
  parameter int OPW   = 4,
  parameter int LAT   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             rsp_overflow,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  input  logic             alu_overflow,
  input  logic             alu_zero
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  logic             last_grant;
  logic             id;
  logic [CW-1:0]    cnt;
  logic             grant0;
  logic             grant1;
  logic             accept;
  logic             div0;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [OPW-1:0]   sel_op;

  always_comb begin
    // On contention the requester that did not win last time is granted.
    grant0     = req0_valid & (~req1_valid | last_grant);
    grant1     = req1_valid & ~grant0;
    // Gated by rst_n so readies read 0 while reset is held.
    req0_ready = rst_n & (state == IDLE) & grant0;
    req1_ready = rst_n & (state == IDLE) & grant1;
    accept     = (state == IDLE) & (grant0 | grant1);
    sel_a      = grant1 ? req1_a  : req0_a;
    sel_b      = grant1 ? req1_b  : req0_b;
    sel_op     = grant1 ? req1_op : req0_op;
`ifdef ALU_DIV0_TRAP_EN
    div0       = (sel_op == OPW'(3)) && (sel_b == '0);
`else
    div0       = 1'b0;
`endif
  end

`ifndef ALU_DIV0_TRAP_EN
  always_comb rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      id           <= 1'b0;
      cnt          <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_op       <= '0;
      rsp0_valid   <= 1'b0;
      rsp1_valid   <= 1'b0;
      rsp_result   <= '0;
      rsp_carry    <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_zero     <= 1'b0;
`ifdef ALU_DIV0_TRAP_EN
      rsp_err      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            last_grant <= grant1;
            id         <= grant1;
            cnt        <= CW'(LAT - 1);
            if (div0) begin
              // Trapped command: straight to RESP, ALU left idle.
              rsp_result   <= '1;
              rsp_carry    <= 1'b0;
              rsp_overflow <= 1'b0;
              rsp_zero     <= 1'b1;
`ifdef ALU_DIV0_TRAP_EN
              rsp_err      <= 1'b1;
`endif
              rsp0_valid   <= ~grant1;
              rsp1_valid   <= grant1;
              state        <= RESP;
            end else begin
              alu_a  <= sel_a;
              alu_b  <= sel_b;
              alu_op <= sel_op;
              state  <= EXEC;
            end
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            rsp_result   <= alu_result;
            rsp_carry    <= alu_carry;
            rsp_overflow <= alu_overflow;
            rsp_zero     <= alu_zero;
`ifdef ALU_DIV0_TRAP_EN
            rsp_err      <= 1'b0;
`endif
            alu_a        <= '0;
            alu_b        <= '0;
            alu_op       <= '0;
            rsp0_valid   <= ~id;
            rsp1_valid   <= id;
            state        <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if ((!id && rsp0_ready) || (id && rsp1_ready)) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
